// File: rtl/fga_pkg.sv
// Shared constants and types for the screen RAM write path.
package fga_pkg;

   localparam int unsigned SCREEN_DEPTH_80x60 = 4800;
   localparam int unsigned SCR_ADDR_W         = 16;
   localparam int unsigned SCR_DATA_W         = 8;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } fill_state_t;

endpackage

// File: rtl/screen_wr_buf.sv
// One-entry CPU write buffer: accepts only when empty, so a write and a refill never share a cycle.
module screen_wr_buf
   import fga_pkg::*;
#(
   parameter int unsigned ADDR_W = SCR_ADDR_W,
   parameter int unsigned DATA_W = SCR_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_take
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              accept;

   assign in_ready  = ~valid_q;
   assign accept    = in_valid & ~valid_q;
   assign out_valid = valid_q;
   assign out_addr  = addr_q;
   assign out_data  = data_q;

   always_comb begin
      valid_d = valid_q;
      if (out_take) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         if (accept) begin
            addr_q <= in_addr;
            data_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/screen_wr_sched.sv
// Screen RAM write-port scheduler: CPU writes take priority, the fill engine uses idle slots.
// Optional fill abort input is built when SCREEN_WR_FILL_ABORT_EN is defined.
module screen_wr_sched
   import fga_pkg::*;
#(
   parameter int unsigned ADDR_W       = SCR_ADDR_W,
   parameter int unsigned DATA_W       = SCR_DATA_W,
   parameter int unsigned SCREEN_DEPTH = SCREEN_DEPTH_80x60
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_hold,
   input  logic              cpu_wr_valid,
   output logic              cpu_wr_ready,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   input  logic              fill_start,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [ADDR_W-1:0] fill_len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              fill_busy,
   output logic              fill_done,
`ifdef SCREEN_WR_FILL_ABORT_EN
   input  logic              fill_abort,
`endif
   output logic [ADDR_W-1:0] ram_wraddr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren
);

   localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(SCREEN_DEPTH - 1);

   fill_state_t       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] remain_q;
   logic [DATA_W-1:0] fdata_q;
   logic [ADDR_W-1:0] wraddr_q;
   logic [DATA_W-1:0] data_q;
   logic              wren_q;

   logic              buf_valid;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;
   logic              issue_cpu;
   logic              issue_fill;
   logic              fill_accept;
   logic              abort;

`ifdef SCREEN_WR_FILL_ABORT_EN
   assign abort = fill_abort & (state_q == FILL);
`else
   assign abort = 1'b0;
`endif

   assign issue_cpu   = buf_valid & ~wr_hold;
   assign issue_fill  = ~buf_valid & ~wr_hold & (state_q == FILL);
   // A start pulse seen under hold is dropped rather than queued.
   assign fill_accept = (state_q == IDLE) & fill_start & ~wr_hold;

   screen_wr_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (cpu_wr_valid),
      .in_ready  (cpu_wr_ready),
      .in_addr   (cpu_wr_addr),
      .in_data   (cpu_wr_data),
      .out_valid (buf_valid),
      .out_addr  (buf_addr),
      .out_data  (buf_data),
      .out_take  (issue_cpu)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (fill_accept) begin
               state_d = (fill_len == '0) ? DONE : FILL;
            end
         end
         FILL: begin
            if (issue_fill && remain_q == ADDR_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Held in DONE so the pulse is not lost while writes are frozen.
            if (!wr_hold) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      fill_busy = (state_q == FILL);
      fill_done = (state_q == DONE) & ~wr_hold;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         remain_q <= '0;
         fdata_q  <= '0;
      end else if (fill_accept) begin
         ptr_q    <= fill_base;
         remain_q <= fill_len;
         fdata_q  <= fill_data;
      end else if (issue_fill) begin
         ptr_q    <= (ptr_q == LastCell) ? '0 : ptr_q + ADDR_W'(1);
         remain_q <= remain_q - ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wren_q   <= 1'b0;
         wraddr_q <= '0;
         data_q   <= '0;
      end else begin
         wren_q <= issue_cpu | issue_fill;
         if (issue_cpu) begin
            wraddr_q <= buf_addr;
            data_q   <= buf_data;
         end else if (issue_fill) begin
            wraddr_q <= ptr_q;
            data_q   <= fdata_q;
         end
      end
   end

   assign ram_wren   = wren_q;
   assign ram_wraddr = wraddr_q;
   assign ram_data   = data_q;

endmodule
